// File: rtl/cpu_pkg.sv
// Shared pipeline definitions for the memory-access stage.
//   - bus widths for execute->memory, memory->write-back and the decode bypass
//   - one-hot load-op bit indices
//   - packed layouts (and field offsets) of the stage buses
package cpu_pkg;

    localparam int unsigned EX_MEM_W  = 76;
    localparam int unsigned MEM_WB_W  = 70;
    localparam int unsigned FWD_BUS_W = 38;

    // ld_op bit indices, bits 4..0 = {hu, bu, w, h, b}
    localparam int unsigned LD_B  = 0;
    localparam int unsigned LD_H  = 1;
    localparam int unsigned LD_W  = 2;
    localparam int unsigned LD_BU = 3;
    localparam int unsigned LD_HU = 4;

    // execute->memory bus field offsets (LSB positions)
    localparam int unsigned EX_PC_LSB   = 0;
    localparam int unsigned EX_ALU_LSB  = 32;
    localparam int unsigned EX_DEST_LSB = 64;
    localparam int unsigned EX_WE_BIT   = 69;
    localparam int unsigned EX_RFM_BIT  = 70;
    localparam int unsigned EX_LDOP_LSB = 71;

    // memory->write-back bus field offsets (LSB positions)
    localparam int unsigned WB_PC_LSB   = 0;
    localparam int unsigned WB_RES_LSB  = 32;
    localparam int unsigned WB_DEST_LSB = 64;
    localparam int unsigned WB_WE_BIT   = 69;

    typedef struct packed {
        logic [4:0]  ld_op;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } ex_mem_bus_t;

    typedef struct packed {
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } mem_wb_bus_t;

    typedef struct packed {
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
    } mem_fwd_t;

endpackage

// File: rtl/mem_stage_if.sv
// Handshake and data buses around the memory-access stage.
//   EX_to_MEM_valid/EX_to_MEM_bus : instruction offered by execute
//   MEM_allow                     : stage can accept this cycle
//   data_sram_rdata               : synchronous data-SRAM read data
//   WB_allow                      : write-back can accept
//   MEM_to_WB_valid/MEM_to_WB_bus : instruction offered to write-back
//   MEM_to_ID_forward             : bypass bundle to decode
// slave  = the stage itself, master = its surrounding pipeline.
interface mem_stage_if
    import cpu_pkg::*;
#(
    parameter int unsigned EX_MEM_BUS_W = EX_MEM_W,
    parameter int unsigned MEM_WB_BUS_W = MEM_WB_W,
    parameter int unsigned FWD_W        = FWD_BUS_W
);
    logic                    EX_to_MEM_valid;
    logic [EX_MEM_BUS_W-1:0] EX_to_MEM_bus;
    logic                    MEM_allow;
    logic [31:0]             data_sram_rdata;
    logic                    WB_allow;
    logic                    MEM_to_WB_valid;
    logic [MEM_WB_BUS_W-1:0] MEM_to_WB_bus;
    logic [FWD_W-1:0]        MEM_to_ID_forward;

    modport slave (
        input  EX_to_MEM_valid, EX_to_MEM_bus, data_sram_rdata, WB_allow,
        output MEM_allow, MEM_to_WB_valid, MEM_to_WB_bus, MEM_to_ID_forward
    );

    modport master (
        output EX_to_MEM_valid, EX_to_MEM_bus, data_sram_rdata, WB_allow,
        input  MEM_allow, MEM_to_WB_valid, MEM_to_WB_bus, MEM_to_ID_forward
    );
endinterface

// File: rtl/mem_load_align.sv
// Load-data alignment and extension (combinational).
//   ld_op   : one-hot {hu, bu, w, h, b}
//   addr    : low two address bits
//   raw     : 32-bit word read from the data SRAM
//   aligned : selected byte/halfword/word, sign- or zero-extended;
//             zero when ld_op is not one-hot
module mem_load_align
    import cpu_pkg::*;
(
    input  logic [4:0]  ld_op,
    input  logic [1:0]  addr,
    input  logic [31:0] raw,
    output logic [31:0] aligned
);
    localparam logic [4:0] OH_B  = 5'(1 << LD_B);
    localparam logic [4:0] OH_H  = 5'(1 << LD_H);
    localparam logic [4:0] OH_W  = 5'(1 << LD_W);
    localparam logic [4:0] OH_BU = 5'(1 << LD_BU);
    localparam logic [4:0] OH_HU = 5'(1 << LD_HU);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = raw[{addr, 3'b000} +: 8];
        // halfword select ignores addr[0]; misalignment is not trapped here
        half_sel = addr[1] ? raw[31:16] : raw[15:0];
        aligned  = '0;
        case (ld_op)
            OH_B:    aligned = {{24{byte_sel[7]}}, byte_sel};
            OH_BU:   aligned = {24'd0, byte_sel};
            OH_H:    aligned = {{16{half_sel[15]}}, half_sel};
            OH_HU:   aligned = {16'd0, half_sel};
            OH_W:    aligned = raw;
            default: aligned = '0;
        endcase
    end
endmodule

// File: rtl/mem_stage.sv
// Memory-access stage of the five-stage in-order pipeline.
//   clk    : pipeline clock
//   resetn : asynchronous active-low reset
//   bus_if : execute/SRAM/write-back/bypass signals (slave view)
// Registers the execute bus, aligns the SRAM read data returned in the
// first occupancy cycle, and keeps that data in rdata_buf while write-back
// stalls so a returned read is never lost.
module mem_stage
    import cpu_pkg::*;
#(
    parameter int unsigned EX_MEM_BUS_W = EX_MEM_W,
    parameter int unsigned MEM_WB_BUS_W = MEM_WB_W,
    parameter int unsigned FWD_W        = FWD_BUS_W
)(
    input  logic        clk,
    input  logic        resetn,
    mem_stage_if.slave  bus_if
);
    logic                    mem_valid;
    logic                    held;
    logic [EX_MEM_BUS_W-1:0] bus_reg_raw;
    ex_mem_bus_t             bus_reg;
    logic [31:0]             rdata_buf;
    logic                    mem_allow;
    logic [31:0]             raw;
    logic [31:0]             aligned;
    logic [31:0]             final_result;
    mem_wb_bus_t             wb_out;
    mem_fwd_t                fwd_out;

    assign bus_reg   = ex_mem_bus_t'(bus_reg_raw);
    assign mem_allow = !mem_valid || bus_if.WB_allow;

    // SRAM data is only valid in the first occupancy cycle; afterwards the
    // buffered copy is authoritative.
    assign raw = held ? rdata_buf : bus_if.data_sram_rdata;

    mem_load_align u_align (
        .ld_op   (bus_reg.ld_op),
        .addr    (bus_reg.alu_result[1:0]),
        .raw     (raw),
        .aligned (aligned)
    );

    assign final_result = bus_reg.res_from_mem ? aligned : bus_reg.alu_result;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_valid   <= 1'b0;
            held        <= 1'b0;
            bus_reg_raw <= '0;
            rdata_buf   <= '0;
        end else begin
            if (mem_allow) begin
                mem_valid <= bus_if.EX_to_MEM_valid;
            end
            if (bus_if.EX_to_MEM_valid && mem_allow) begin
                bus_reg_raw <= bus_if.EX_to_MEM_bus;
            end
            if (mem_allow) begin
                held <= 1'b0;
            end else if (mem_valid && !bus_if.WB_allow && !held) begin
                rdata_buf <= bus_if.data_sram_rdata;
                held      <= 1'b1;
            end
        end
    end

    always_comb begin
        wb_out.gr_we        = bus_reg.gr_we;
        wb_out.dest         = bus_reg.dest;
        wb_out.final_result = final_result;
        wb_out.pc           = bus_reg.pc;

        fwd_out.gr_we        = bus_reg.gr_we & mem_valid;
        fwd_out.dest         = bus_reg.dest & {5{mem_valid}};
        fwd_out.final_result = final_result;
    end

    assign bus_if.MEM_allow         = mem_allow;
    assign bus_if.MEM_to_WB_valid   = mem_valid;
    assign bus_if.MEM_to_WB_bus     = MEM_WB_BUS_W'(wb_out);
    assign bus_if.MEM_to_ID_forward = FWD_W'(fwd_out);
endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
    logic clk;
    logic resetn;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    logic [69:0] exp_q[$];

    mem_stage_if #(
        .EX_MEM_BUS_W (76),
        .MEM_WB_BUS_W (70),
        .FWD_W        (38)
    ) ifc ();

    mem_stage #(
        .EX_MEM_BUS_W (76),
        .MEM_WB_BUS_W (70),
        .FWD_W        (38)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus_if (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [75:0] mk_ex(input logic [4:0] ld_op, input logic rfm,
                                          input logic we, input logic [4:0] dest,
                                          input logic [31:0] alu, input logic [31:0] pc);
        return {ld_op, rfm, we, dest, alu, pc};
    endfunction

    function automatic logic [69:0] mk_wb(input logic we, input logic [4:0] dest,
                                          input logic [31:0] res, input logic [31:0] pc);
        return {we, dest, res, pc};
    endfunction

    task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares every presented output against the scoreboard head;
    // the head retires only when write-back accepts it.
    always @(negedge clk) begin
        if (resetn === 1'b1 && ifc.MEM_to_WB_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: got %h expected none", ifc.MEM_to_WB_bus);
            end else begin
                chk("wb_bus", ifc.MEM_to_WB_bus, exp_q[0]);
                chk("fwd", 70'(ifc.MEM_to_ID_forward), 70'({exp_q[0][69:32]}));
                if (ifc.WB_allow) void'(exp_q.pop_front());
            end
        end
    end

    // Offer one instruction; the read data appears in its first cycle here.
    task automatic send(input logic [75:0] b, input logic [31:0] rd, input logic [69:0] e);
        ifc.EX_to_MEM_valid = 1'b1;
        ifc.EX_to_MEM_bus   = b;
        @(posedge clk); #1;
        ifc.data_sram_rdata = rd;
        exp_q.push_back(e);
        ifc.EX_to_MEM_valid = 1'b0;
    endtask

    initial begin
        resetn              = 1'b0;
        ifc.WB_allow        = 1'b1;
        ifc.data_sram_rdata = 32'h0;
        ifc.EX_to_MEM_valid = 1'b1;
        ifc.EX_to_MEM_bus   = mk_ex(5'b00000, 1'b0, 1'b1, 5'd5, 32'h11, 32'h100);

        // reset held with a valid instruction waiting upstream
        repeat (3) begin
            @(negedge clk);
            chk("rst_valid", 70'(ifc.MEM_to_WB_valid), 70'd0);
            chk("rst_allow", 70'(ifc.MEM_allow), 70'd1);
            chk("rst_fwd", 70'(ifc.MEM_to_ID_forward), 70'd0);
            chk("rst_bus", ifc.MEM_to_WB_bus, 70'd0);
        end
        @(posedge clk); #1;
        resetn = 1'b1;

        // ALU pass-through, first output one cycle after release
        @(posedge clk); #1;
        exp_q.push_back(mk_wb(1'b1, 5'd5, 32'h11, 32'h100));
        ifc.EX_to_MEM_valid = 1'b0;
        @(negedge clk);
        chk("first_valid", 70'(ifc.MEM_to_WB_valid), 70'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bubble_valid", 70'(ifc.MEM_to_WB_valid), 70'd0);
        chk("bubble_fwd_we_dest", 70'(ifc.MEM_to_ID_forward[37:32]), 70'd0);

        // byte loads
        send(mk_ex(5'b00001, 1'b1, 1'b1, 5'd3, 32'h1000_0003, 32'h200), 32'h80FF_1234,
             mk_wb(1'b1, 5'd3, 32'hFFFF_FF80, 32'h200));
        send(mk_ex(5'b01000, 1'b1, 1'b1, 5'd4, 32'h1000_0003, 32'h204), 32'h80FF_1234,
             mk_wb(1'b1, 5'd4, 32'h0000_0080, 32'h204));
        send(mk_ex(5'b00001, 1'b1, 1'b1, 5'd6, 32'h1000_0001, 32'h208), 32'h80FF_1234,
             mk_wb(1'b1, 5'd6, 32'h0000_0012, 32'h208));
        send(mk_ex(5'b01000, 1'b1, 1'b1, 5'd8, 32'h1000_0002, 32'h20C), 32'h80FF_1234,
             mk_wb(1'b1, 5'd8, 32'h0000_00FF, 32'h20C));

        // halfword / word loads
        send(mk_ex(5'b00010, 1'b1, 1'b1, 5'd10, 32'h1000_0002, 32'h210), 32'h8001_7FFF,
             mk_wb(1'b1, 5'd10, 32'hFFFF_8001, 32'h210));
        send(mk_ex(5'b10000, 1'b1, 1'b1, 5'd11, 32'h1000_0000, 32'h214), 32'h8001_7FFF,
             mk_wb(1'b1, 5'd11, 32'h0000_7FFF, 32'h214));
        send(mk_ex(5'b00010, 1'b1, 1'b1, 5'd12, 32'h1000_0003, 32'h218), 32'h8001_7FFF,
             mk_wb(1'b1, 5'd12, 32'hFFFF_8001, 32'h218));
        send(mk_ex(5'b10000, 1'b1, 1'b1, 5'd13, 32'h1000_0002, 32'h21C), 32'h8001_7FFF,
             mk_wb(1'b1, 5'd13, 32'h0000_8001, 32'h21C));
        send(mk_ex(5'b00100, 1'b1, 1'b1, 5'd14, 32'h1000_0002, 32'h220), 32'h8001_7FFF,
             mk_wb(1'b1, 5'd14, 32'h8001_7FFF, 32'h220));
        send(mk_ex(5'b00011, 1'b1, 1'b1, 5'd15, 32'h1000_0000, 32'h224), 32'h8001_7FFF,
             mk_wb(1'b1, 5'd15, 32'h0000_0000, 32'h224));
        send(mk_ex(5'b00000, 1'b0, 1'b0, 5'd16, 32'hABCD_0123, 32'h228), 32'h8001_7FFF,
             mk_wb(1'b0, 5'd16, 32'hABCD_0123, 32'h228));
        @(posedge clk); #1;

        // stall hold: load enters while write-back is blocked
        ifc.WB_allow        = 1'b0;
        ifc.EX_to_MEM_valid = 1'b1;
        ifc.EX_to_MEM_bus   = mk_ex(5'b00100, 1'b1, 1'b1, 5'd7, 32'h1000_0000, 32'h300);
        @(posedge clk); #1;
        ifc.data_sram_rdata = 32'h1234_5678;
        exp_q.push_back(mk_wb(1'b1, 5'd7, 32'h1234_5678, 32'h300));
        ifc.EX_to_MEM_bus   = mk_ex(5'b00100, 1'b1, 1'b1, 5'd17, 32'h1000_0004, 32'h304);
        @(negedge clk);
        chk("stall_allow_1", 70'(ifc.MEM_allow), 70'd0);
        @(posedge clk); #1;
        ifc.data_sram_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("stall_allow_2", 70'(ifc.MEM_allow), 70'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("stall_allow_3", 70'(ifc.MEM_allow), 70'd0);
        @(posedge clk); #1;
        ifc.WB_allow = 1'b1;
        @(negedge clk);
        chk("release_allow", 70'(ifc.MEM_allow), 70'd1);
        @(posedge clk); #1;
        ifc.data_sram_rdata = 32'hCAFE_F00D;
        exp_q.push_back(mk_wb(1'b1, 5'd17, 32'hCAFE_F00D, 32'h304));
        ifc.EX_to_MEM_valid = 1'b0;
        @(posedge clk); #1;

        // reset asserted in the middle of a stalled load
        ifc.WB_allow        = 1'b0;
        ifc.EX_to_MEM_valid = 1'b1;
        ifc.EX_to_MEM_bus   = mk_ex(5'b00100, 1'b1, 1'b1, 5'd9, 32'h1000_0008, 32'h400);
        @(posedge clk); #1;
        ifc.data_sram_rdata = 32'h55AA_55AA;
        exp_q.push_back(mk_wb(1'b1, 5'd9, 32'h55AA_55AA, 32'h400));
        ifc.EX_to_MEM_valid = 1'b0;
        @(posedge clk); #1;
        ifc.data_sram_rdata = 32'h0;
        #2;
        resetn = 1'b0;
        #1;
        chk("async_rst_valid", 70'(ifc.MEM_to_WB_valid), 70'd0);
        chk("async_rst_allow", 70'(ifc.MEM_allow), 70'd1);
        chk("async_rst_fwd", 70'(ifc.MEM_to_ID_forward), 70'd0);
        exp_q.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        resetn       = 1'b1;
        ifc.WB_allow = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", 70'(ifc.MEM_to_WB_valid), 70'd0);
        // a stale held flag would substitute the cleared buffer for fresh data
        send(mk_ex(5'b00100, 1'b1, 1'b1, 5'd18, 32'h1000_000C, 32'h500), 32'h0BAD_F00D,
             mk_wb(1'b1, 5'd18, 32'h0BAD_F00D, 32'h500));
        @(posedge clk); #1;
        @(negedge clk);

        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
